// File: rtl/seq_alu.sv
// Clocked button-select ALU: debounced push buttons launch add/sub/leading-ones
// in one cycle, and shift-add multiply or bit-serial popcount over several cycles.
module seq_alu #(
  parameter int          BITS     = 16,
  parameter logic [15:0] DEBOUNCE = 16'd50000
) (
  input  logic            CLK100MHZ,
  input  logic            CPU_RESETN,
  input  logic [BITS-1:0] SW,
  input  logic            BTNC,
  input  logic            BTNU,
  input  logic            BTND,
  input  logic            BTNL,
  input  logic            BTNR,
  output logic [BITS-1:0] LED,
  output logic            BUSY
);

  localparam int H  = BITS / 2;
  localparam int CW = $clog2(DEBOUNCE);
  localparam int KW = $clog2(BITS) + 1;
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE - 16'd1);
  localparam logic [KW-1:0] MUL_LAST = KW'(H - 1);
  localparam logic [KW-1:0] NO_LAST  = KW'(BITS - 1);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_LO  = 3'd3,
    OP_NO  = 3'd4
  } op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  function automatic logic [KW-1:0] lead_pos(input logic [BITS-1:0] v);
    logic [KW-1:0] pos;
    pos = {KW{1'b0}};
    for (int i = 0; i < BITS; i++) begin
      if (v[i]) begin
        pos = KW'(i + 1);
      end else begin
        pos = pos;
      end
    end
    return pos;
  endfunction

  // Bit order C,U,D,L,R from MSB down doubles as the priority order.
  logic [4:0]    btn_s;
  logic [4:0]    sync1_r;
  logic [4:0]    sync2_r;
  logic [4:0]    level_r;
  logic [4:0]    press_r;
  logic [CW-1:0] cnt_r [5];

  assign btn_s = {BTNC, BTNU, BTND, BTNL, BTNR};

  // Two-flop synchroniser, per-button stability counter and press pulse.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sync1_r <= 5'b0;
      sync2_r <= 5'b0;
      level_r <= 5'b0;
      press_r <= 5'b0;
      for (int i = 0; i < 5; i++) begin
        cnt_r[i] <= {CW{1'b0}};
      end
    end else begin
      sync1_r <= btn_s;
      sync2_r <= sync1_r;
      for (int i = 0; i < 5; i++) begin
        if (sync2_r[i] != level_r[i]) begin
          if (cnt_r[i] == DB_LAST) begin
            level_r[i] <= sync2_r[i];
            cnt_r[i]   <= {CW{1'b0}};
            press_r[i] <= sync2_r[i];
          end else begin
            cnt_r[i]   <= cnt_r[i] + {{(CW-1){1'b0}}, 1'b1};
            press_r[i] <= 1'b0;
          end
        end else begin
          cnt_r[i]   <= {CW{1'b0}};
          press_r[i] <= 1'b0;
        end
      end
    end
  end

  logic sel_valid_s;
  op_t  sel_op_s;

  // Fixed-priority choice among simultaneous presses.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_op_s    = OP_ADD;
    if (press_r[4]) begin
      sel_valid_s = 1'b1;
      sel_op_s    = OP_MUL;
    end else if (press_r[3]) begin
      sel_valid_s = 1'b1;
      sel_op_s    = OP_LO;
    end else if (press_r[2]) begin
      sel_valid_s = 1'b1;
      sel_op_s    = OP_NO;
    end else if (press_r[1]) begin
      sel_valid_s = 1'b1;
      sel_op_s    = OP_ADD;
    end else if (press_r[0]) begin
      sel_valid_s = 1'b1;
      sel_op_s    = OP_SUB;
    end else begin
      sel_valid_s = 1'b0;
    end
  end

  state_t          state_r;
  op_t             op_r;
  logic [BITS-1:0] mcand_r;
  logic [BITS-1:0] shift_r;
  logic [BITS-1:0] acc_r;
  logic [KW-1:0]   cyc_r;
  logic [BITS-1:0] led_r;
  logic            busy_r;

  logic [BITS-1:0] b_ext_s;
  logic [BITS-1:0] addend_s;
  logic [BITS-1:0] result_s;
  logic [KW-1:0]   last_idx_s;
  logic            last_s;

  assign b_ext_s  = {{H{shift_r[H-1]}}, shift_r[H-1:0]};
  assign addend_s = shift_r[0] ? mcand_r : {BITS{1'b0}};
  assign last_s   = (cyc_r == last_idx_s);

  // Per-cycle datapath; the final multiply step subtracts the sign-bit partial product.
  always_comb begin
    last_idx_s = {KW{1'b0}};
    result_s   = acc_r;
    case (op_r)
      OP_ADD: result_s = mcand_r + b_ext_s;
      OP_SUB: result_s = mcand_r - b_ext_s;
      OP_MUL: begin
        last_idx_s = MUL_LAST;
        result_s   = last_s ? (acc_r - addend_s) : (acc_r + addend_s);
      end
      OP_LO:  result_s = {{(BITS-KW){1'b0}}, lead_pos(shift_r)};
      OP_NO: begin
        last_idx_s = NO_LAST;
        result_s   = acc_r + {{(BITS-1){1'b0}}, shift_r[0]};
      end
      default: result_s = acc_r;
    endcase
  end

  // IDLE/EXEC control with registered LED and BUSY.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_r <= ST_IDLE;
      op_r    <= OP_ADD;
      mcand_r <= {BITS{1'b0}};
      shift_r <= {BITS{1'b0}};
      acc_r   <= {BITS{1'b0}};
      cyc_r   <= {KW{1'b0}};
      led_r   <= {BITS{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (sel_valid_s) begin
            op_r    <= sel_op_s;
            mcand_r <= {{H{SW[BITS-1]}}, SW[BITS-1:H]};
            shift_r <= (sel_op_s == OP_MUL) ? {{H{1'b0}}, SW[H-1:0]} : SW;
            acc_r   <= {BITS{1'b0}};
            cyc_r   <= {KW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= ST_EXEC;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        ST_EXEC: begin
          if (last_s) begin
            led_r   <= result_s;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            acc_r   <= result_s;
            shift_r <= shift_r >> 1;
            mcand_r <= mcand_r << 1;
            cyc_r   <= cyc_r + {{(KW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign LED  = led_r;
  assign BUSY = busy_r;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: vector table (directed + random against a
// behavioural model) and hand-written bounce, priority and reset sequences.
module tb_seq_alu;

  localparam int BITS = 16;

  logic            clk;
  logic            rst_n;
  logic [BITS-1:0] sw;
  logic [4:0]      btn;   // 4=C 3=U 2=D 1=L 0=R
  logic [BITS-1:0] led;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int starts = 0;
  logic busy_q = 1'b0;
  logic [15:0] last_led;

  seq_alu #(.BITS(BITS), .DEBOUNCE(16'd4)) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .SW        (sw),
    .BTNC      (btn[4]),
    .BTNU      (btn[3]),
    .BTND      (btn[2]),
    .BTNL      (btn[1]),
    .BTNR      (btn[0]),
    .LED       (led),
    .BUSY      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy && !busy_q) starts++;
    busy_q = busy;
  end

  typedef struct {
    int          op;
    logic [15:0] sw;
    logic [15:0] exp_led;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[$];

  // Reference: operation semantics straight from the arithmetic definitions.
  function automatic logic [15:0] ref_result(input int op, input logic [15:0] v);
    int a, b, r;
    a = int'($signed(v[15:8]));
    b = int'($signed(v[7:0]));
    r = 0;
    case (op)
      4: r = a * b;
      3: for (int i = 0; i < 16; i++) if (v[i]) r = i + 1;
      2: r = $countones(v);
      1: r = a + b;
      0: r = a - b;
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  function automatic int ref_cycles(input int op);
    return (op == 4) ? 8 : (op == 2) ? 16 : 1;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input int idx);
    int n;
    int c;
    sw = v.sw;
    btn[v.op] = 1'b1;
    n = 0;
    while (!busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!busy) begin
      chk($sformatf("vec%0d_start_timeout", idx), 16'(busy), 16'd1);
    end else begin
      chk($sformatf("vec%0d_led_hold", idx), led, last_led);
      c = 0;
      while (busy && c < 40) begin
        @(negedge clk);
        c++;
      end
      chk($sformatf("vec%0d_busy_cycles", idx), 16'(c), 16'(v.exp_cyc));
      chk($sformatf("vec%0d_led", idx), led, v.exp_led);
      last_led = v.exp_led;
    end
    btn[v.op] = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_busy(input string name);
    int n;
    n = 0;
    while (!busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!busy) chk(name, 16'(busy), 16'd1);
  endtask

  initial begin
    int s0;
    logic [15:0] r;
    rst_n = 1'b0;
    sw = 16'h0000;
    btn = 5'b0;
    last_led = 16'h0000;
    repeat (3) @(negedge clk);
    chk("reset_led", led, 16'h0000);
    chk("reset_busy", 16'(busy), 16'h0000);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    vecs.push_back('{1, 16'h05FD, 16'h0002, 1});
    vecs.push_back('{4, 16'h8080, 16'h4000, 8});
    vecs.push_back('{4, 16'hFF02, 16'hFFFE, 8});
    vecs.push_back('{2, 16'hFFFF, 16'h0010, 16});
    vecs.push_back('{3, 16'h0000, 16'h0000, 1});
    vecs.push_back('{3, 16'h0100, 16'h0009, 1});
    vecs.push_back('{0, 16'h807F, 16'hFF01, 1});
    vecs.push_back('{4, 16'h7F7F, 16'h3F01, 8});
    vecs.push_back('{2, 16'h0000, 16'h0000, 16});
    for (int i = 0; i < 12; i++) begin
      vec_t v;
      v.op = int'($urandom_range(0, 4));
      r = 16'($urandom);
      v.sw = r;
      v.exp_led = ref_result(v.op, r);
      v.exp_cyc = ref_cycles(v.op);
      vecs.push_back(v);
    end
    for (int i = 0; i < vecs.size(); i++) run_op(vecs[i], i);

    // Bounce: toggling never stable long enough, then held -> one SUB.
    s0 = starts;
    sw = 16'h0A03;
    for (int i = 0; i < 10; i++) begin
      btn[0] = ~btn[0];
      repeat (2) @(negedge clk);
    end
    btn[0] = 1'b1;
    repeat (40) @(negedge clk);
    chk("bounce_one_op", 16'(starts - s0), 16'd1);
    chk("bounce_led", led, 16'h0007);
    btn[0] = 1'b0;
    repeat (12) @(negedge clk);
    s0 = starts;
    btn[0] = 1'b1;
    repeat (3) @(negedge clk);
    btn[0] = 1'b0;
    repeat (20) @(negedge clk);
    chk("short_pulse_no_op", 16'(starts - s0), 16'd0);
    chk("short_pulse_led", led, 16'h0007);

    // Simultaneous C and L: multiply wins, add dropped.
    s0 = starts;
    sw = 16'h0304;
    btn[4] = 1'b1;
    btn[1] = 1'b1;
    repeat (40) @(negedge clk);
    chk("prio_one_op", 16'(starts - s0), 16'd1);
    chk("prio_led", led, ref_result(4, 16'h0304));
    btn = 5'b0;
    repeat (12) @(negedge clk);

    // U pressed one cycle after C lands inside the multiply and is discarded.
    s0 = starts;
    sw = 16'hFD05;
    btn[4] = 1'b1;
    @(negedge clk);
    btn[3] = 1'b1;
    repeat (40) @(negedge clk);
    chk("exec_drop_one_op", 16'(starts - s0), 16'd1);
    chk("exec_drop_led", led, 16'hFFF1);
    btn = 5'b0;
    repeat (12) @(negedge clk);

    // Reset during EXEC cycle 4 of a multiply.
    sw = 16'h0707;
    btn[4] = 1'b1;
    wait_busy("rst_mid_start_timeout");
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    btn = 5'b0;
    #1;
    chk("rst_mid_led", led, 16'h0000);
    chk("rst_mid_busy", 16'(busy), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("rst_after_led", led, 16'h0000);
    chk("rst_after_busy", 16'(busy), 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
